// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer sequencer: FSM states, timer register map,
// control words, and the Avalon-MM bus beat type with small builders.
// Pure declarations, no logic or latency of its own.
package timer_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_STOP,
        WR_PL,
        WR_PH,
        WR_CTRL,
        WAIT_IRQ,
        RD_STAT,
        RD_CHK,
        WR_CLR,
        NEXT,
        ABORT
    } state_t;

    // Interval timer register addresses
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;

    // Control/status words
    localparam logic [15:0] CTRL_STOP      = 16'h0008;
    localparam logic [15:0] CTRL_START_ITO = 16'h0005;
    localparam logic [15:0] STATUS_CLR     = 16'h0000;

    // One cycle of the timer bus
    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'h0000};

    function automatic bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        bus_t b;
        b.cs      = 1'b1;
        b.write_n = 1'b0;
        b.addr    = addr;
        b.wdata   = data;
        return b;
    endfunction

    function automatic bus_t bus_read(input logic [2:0] addr);
        bus_t b;
        b.cs      = 1'b1;
        b.write_n = 1'b1;
        b.addr    = addr;
        b.wdata   = 16'h0000;
        return b;
    endfunction

endpackage

// File: rtl/timer_seq_table.sv
// Period table: NUM_SLOTS x 32-bit register file, one write port, one async read port.
// Write lands on the next clock edge; read is combinational (out-of-range reads as 0).
// No backpressure; the caller gates wr_en.
module timer_seq_table #(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [NUM_SLOTS];

    // Storage: cleared on reset, writes to indices past the table are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (int'(wr_idx) < NUM_SLOTS)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read port: an index past the table reads as 0, which the sequencer treats as end-of-list
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < NUM_SLOTS) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Walks a table of periods, programming an Avalon interval timer once per slot and waiting for its timeout.
// First bus write one cycle after start; 4 write cycles per slot, then irq wait, status read/check, clear.
// No backpressure: the timer bus is fixed-timing; stop aborts from any active state.
module timer_sequencer #(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_wr,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [31:0]      cfg_period,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    output logic             busy,
    output logic             slot_done,
    output logic [IDX_W-1:0] slot_idx,
    output logic             spurious,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq
);
    import timer_seq_pkg::*;

    localparam logic [IDX_W:0] SLOT_LIMIT = (IDX_W+1)'(NUM_SLOTS);
    localparam logic [IDX_W:0] ONE        = (IDX_W+1)'(1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [IDX_W:0]   idx_inc;
    logic [IDX_W-1:0] tbl_rd_idx;
    logic [31:0]      tbl_rd_data;
    logic             tbl_wr_en;
    bus_t             bus;
    logic             unused_rd;

    // Only the TO bit of the status register matters
    assign unused_rd = ^tmr_readdata[15:1];

    // Extra bit so that stepping past the last slot is seen rather than wrapping silently
    assign idx_inc   = {1'b0, idx} + ONE;

    // Table may only be reprogrammed while the sequencer is idle
    assign tbl_wr_en = cfg_wr && (state == IDLE);

    timer_seq_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tbl_wr_en),
        .wr_idx  (cfg_idx),
        .wr_data (cfg_period),
        .rd_idx  (tbl_rd_idx),
        .rd_data (tbl_rd_data)
    );

    // State and slot index registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state, table read address, bus beat and status pulses
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        tbl_rd_idx = idx;
        bus        = BUS_IDLE;
        slot_done  = 1'b0;
        spurious   = 1'b0;

        case (state)
            IDLE: begin
                // Look at slot 0 so an empty table refuses to start
                tbl_rd_idx = '0;
                if (start && !stop && (tbl_rd_data != 32'd0)) begin
                    idx_nxt   = '0;
                    state_nxt = WR_STOP;
                end
            end
            WR_STOP: begin
                bus       = bus_write(ADDR_CONTROL, CTRL_STOP);
                state_nxt = WR_PL;
            end
            WR_PL: begin
                bus       = bus_write(ADDR_PERIODL, tbl_rd_data[15:0]);
                state_nxt = WR_PH;
            end
            WR_PH: begin
                bus       = bus_write(ADDR_PERIODH, tbl_rd_data[31:16]);
                state_nxt = WR_CTRL;
            end
            WR_CTRL: begin
                bus       = bus_write(ADDR_CONTROL, CTRL_START_ITO);
                state_nxt = WAIT_IRQ;
            end
            WAIT_IRQ: begin
                if (tmr_irq) begin
                    state_nxt = RD_STAT;
                end
            end
            RD_STAT: begin
                bus       = bus_read(ADDR_STATUS);
                state_nxt = RD_CHK;
            end
            RD_CHK: begin
                // Readdata belongs to the read issued in RD_STAT
                if (tmr_readdata[0]) begin
                    state_nxt = WR_CLR;
                end else begin
                    spurious  = 1'b1;
                    state_nxt = WAIT_IRQ;
                end
            end
            WR_CLR: begin
                bus       = bus_write(ADDR_STATUS, STATUS_CLR);
                slot_done = 1'b1;
                state_nxt = NEXT;
            end
            NEXT: begin
                // Peek at the following slot to decide between continue, wrap and finish
                tbl_rd_idx = idx_inc[IDX_W-1:0];
                if ((idx_inc >= SLOT_LIMIT) || (tbl_rd_data == 32'd0)) begin
                    idx_nxt   = '0;
                    state_nxt = loop_en ? WR_STOP : IDLE;
                end else begin
                    idx_nxt   = idx_inc[IDX_W-1:0];
                    state_nxt = WR_STOP;
                end
            end
            ABORT: begin
                bus       = bus_write(ADDR_CONTROL, CTRL_STOP);
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        // Abort request overrides any active state's own transition
        if (stop && (state != IDLE) && (state != ABORT)) begin
            state_nxt = ABORT;
        end
    end

    assign busy           = (state != IDLE);
    assign slot_idx       = idx;
    assign tmr_chipselect = bus.cs;
    assign tmr_write_n    = bus.write_n;
    assign tmr_address    = bus.addr;
    assign tmr_writedata  = bus.wdata;

endmodule
